// File: rtl/niosii_irq_pkg.sv
// Shared constants for the Nios II style interrupt controller.
// Register map, source limit and a source-mask helper.
package niosii_irq_pkg;

  localparam int NUM_SRC_MAX = 16;

  typedef logic [2:0] addr_t;

  localparam addr_t ADDR_STATUS  = 3'd0;
  localparam addr_t ADDR_PENDING = 3'd1;
  localparam addr_t ADDR_ENABLE  = 3'd2;
  localparam addr_t ADDR_EN_SET  = 3'd3;
  localparam addr_t ADDR_EN_CLR  = 3'd4;
  localparam addr_t ADDR_ACTIVE  = 3'd5;
  localparam addr_t ADDR_FORCE   = 3'd6;

  function automatic logic [15:0] src_mask(input int n);
    if (n >= NUM_SRC_MAX)
      src_mask = 16'hFFFF;
    else
      src_mask = 16'((32'd1 << n) - 32'd1);
  endfunction

endpackage

// File: rtl/niosii_irq_prio_enc.sv
// Lowest-index-first 16-bit priority encoder.
// valid_o flags any request; id_o is 0 when none.
module niosii_irq_prio_enc (
  input  logic [15:0] req_i,
  output logic        valid_o,
  output logic [3:0]  id_o
);

  always_comb begin
    valid_o = |req_i;
    id_o    = '0;
    for (int i = 15; i >= 0; i--) begin
      if (req_i[i]) id_o = 4'(i);
    end
  end

endmodule

// File: rtl/niosii_irq_ctrl.sv
// Avalon-MM interrupt controller: edge/level sources,
// W1C pending, enable mask, lowest-index active id.
module niosii_irq_ctrl
  import niosii_irq_pkg::*;
#(
  parameter int          NUM_SRC   = 8,
  parameter logic [15:0] EDGE_MASK = 16'h0001
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [2:0]         address,
  input  logic               chipselect,
  input  logic               write_n,
  input  logic [15:0]        writedata,
  output logic [15:0]        readdata,
  input  logic [NUM_SRC-1:0] irq_in,
  output logic               irq
);

  localparam logic [15:0] SRC_M  = src_mask(NUM_SRC);
  localparam logic [15:0] EDGE_M = EDGE_MASK & SRC_M;
  localparam logic [15:0] LVL_M  = ~EDGE_MASK & SRC_M;

  logic [15:0] in_w;
  logic [15:0] sync_q;
  logic [15:0] epend_q, epend_d;
  logic [15:0] en_q, en_d;
  logic [15:0] rd_q, rd_d;
  logic        irq_q;
  logic        armed_q;

  logic        wr;
  logic [15:0] pend_w;
  logic [15:0] act_w;
  logic [15:0] rise_w;
  logic [15:0] set_w;
  logic [15:0] clr_w;
  logic        act_vld;
  logic [3:0]  act_id;

  assign in_w = 16'(irq_in);
  assign wr   = chipselect & ~write_n;

  assign pend_w = (epend_q & EDGE_M)
                | (sync_q & LVL_M);
  assign act_w  = pend_w & en_q;

  // armed_q blocks a false edge on the first
  // cycle after reset, when sync_q is still 0.
  assign rise_w = in_w & ~sync_q & EDGE_M
                & {16{armed_q}};

  always_comb begin
    set_w = rise_w;
    clr_w = '0;
    if (wr && address == ADDR_FORCE)
      set_w = rise_w | (writedata & EDGE_M);
    if (wr && address == ADDR_PENDING)
      clr_w = writedata & EDGE_M;
  end

  assign epend_d = ((epend_q & ~clr_w) | set_w)
                 & EDGE_M;

  always_comb begin
    en_d = en_q;
    if (wr) begin
      unique case (address)
        ADDR_ENABLE: en_d = writedata & SRC_M;
        ADDR_EN_SET: en_d = en_q | (writedata & SRC_M);
        ADDR_EN_CLR: en_d = en_q & ~writedata;
        default:     en_d = en_q;
      endcase
    end
  end

  niosii_irq_prio_enc u_enc (
    .req_i   (act_w),
    .valid_o (act_vld),
    .id_o    (act_id)
  );

  always_comb begin
    unique case (address)
      ADDR_STATUS:  rd_d = sync_q;
      ADDR_PENDING: rd_d = pend_w;
      ADDR_ENABLE:  rd_d = en_q;
      ADDR_ACTIVE:  rd_d = {act_vld, 11'd0, act_id};
      default:      rd_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q  <= '0;
      epend_q <= '0;
      en_q    <= '0;
      rd_q    <= '0;
      irq_q   <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      sync_q  <= in_w & SRC_M;
      epend_q <= epend_d;
      en_q    <= en_d;
      rd_q    <= rd_d;
      irq_q   <= |act_w;
      armed_q <= 1'b1;
    end
  end

  assign readdata = rd_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_niosii_irq_ctrl.sv
// Bench for niosii_irq_ctrl: directed vector table
// followed by random traffic against a behavioural model.
module tb_niosii_irq_ctrl;

  localparam int          NSRC = 8;
  localparam logic [15:0] EMSK = 16'h0001;

  logic        clk;
  logic        reset;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [15:0] writedata;
  logic [15:0] readdata;
  logic [7:0]  irq_in;
  logic        irq;

  int checks;
  int errors;

  niosii_irq_ctrl #(
    .NUM_SRC   (NSRC),
    .EDGE_MASK (EMSK)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq_in     (irq_in),
    .irq        (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          rst;
    logic [2:0]  a;
    bit          cs;
    bit          wn;
    logic [15:0] wd;
    logic [7:0]  in;
    logic [15:0] rd;
    bit          irq;
  } vec_t;

  vec_t vq[$];

  // behavioural model: one bit per source
  logic [15:0] em;
  bit          m_prev[16];
  bit          m_ep[16];
  bit          m_en[16];
  bit          m_armed;
  logic [15:0] m_rd;
  bit          m_irq;

  function automatic void model_step(
    input bit rst, input logic [2:0] a,
    input bit cs, input bit wn,
    input logic [15:0] wd, input logic [7:0] in);
    bit any;
    int low;
    logic [15:0] pv, sv, ev;
    bit wr, p, s, c;
    if (rst) begin
      for (int i = 0; i < 16; i++) begin
        m_prev[i] = 0; m_ep[i] = 0; m_en[i] = 0;
      end
      m_armed = 0; m_rd = 0; m_irq = 0;
      return;
    end
    any = 0; low = 0; pv = 0; sv = 0; ev = 0;
    for (int i = 0; i < NSRC; i++) begin
      p = em[i] ? m_ep[i] : m_prev[i];
      pv[i] = p; sv[i] = m_prev[i]; ev[i] = m_en[i];
      if (p && m_en[i]) begin
        if (!any) low = i;
        any = 1;
      end
    end
    case (a)
      3'd0: m_rd = sv;
      3'd1: m_rd = pv;
      3'd2: m_rd = ev;
      3'd5: m_rd = any ? (16'h8000 + 16'(low)) : 16'h0;
      default: m_rd = 0;
    endcase
    m_irq = any;
    wr = cs && !wn;
    for (int i = 0; i < NSRC; i++) begin
      if (wr && a == 3'd2) m_en[i] = wd[i];
      if (wr && a == 3'd3 && wd[i]) m_en[i] = 1;
      if (wr && a == 3'd4 && wd[i]) m_en[i] = 0;
      if (em[i]) begin
        s = (m_armed && in[i] && !m_prev[i])
          || (wr && a == 3'd6 && wd[i]);
        c = wr && a == 3'd1 && wd[i];
        if (s) m_ep[i] = 1;
        else if (c) m_ep[i] = 0;
      end
      m_prev[i] = in[i];
    end
    m_armed = 1;
  endfunction

  task automatic add(input bit rst, input logic [2:0] a,
    input bit cs, input bit wn, input logic [15:0] wd,
    input logic [7:0] in, input logic [15:0] rd,
    input bit iq);
    vq.push_back('{rst, a, cs, wn, wd, in, rd, iq});
  endtask

  task automatic R(input logic [2:0] a, input logic [7:0] in,
    input logic [15:0] rd, input bit iq);
    add(0, a, 1, 1, 16'h0, in, rd, iq);
  endtask

  task automatic W(input logic [2:0] a, input logic [15:0] wd,
    input logic [7:0] in, input logic [15:0] rd, input bit iq);
    add(0, a, 1, 0, wd, in, rd, iq);
  endtask

  task automatic X(input logic [7:0] in);
    add(1, 3'd0, 0, 1, 16'h0, in, 16'h0, 0);
  endtask

  task automatic drive(input bit rst, input logic [2:0] a,
    input bit cs, input bit wn, input logic [15:0] wd,
    input logic [7:0] in);
    @(negedge clk);
    reset = rst; address = a; chipselect = cs;
    write_n = wn; writedata = wd; irq_in = in;
    @(posedge clk);
    model_step(rst, a, cs, wn, wd, in);
    #1;
  endtask

  task automatic cmp(input string nm, input int idx,
    input logic [15:0] rd_exp, input bit irq_exp);
    checks++;
    if (readdata !== rd_exp) begin
      errors++;
      $display("FAIL %s[%0d] readdata got %h want %h",
        nm, idx, readdata, rd_exp);
    end
    checks++;
    if (irq !== irq_exp) begin
      errors++;
      $display("FAIL %s[%0d] irq got %b want %b",
        nm, idx, irq, irq_exp);
    end
  endtask

  initial begin
    logic [7:0]  rin;
    logic [2:0]  ra;
    bit          rr, rc, rw;
    logic [15:0] rwd;
    checks = 0; errors = 0;
    em = EMSK;
    reset = 1; address = 0; chipselect = 0;
    write_n = 1; writedata = 0; irq_in = 0;

    X(8'h00); X(8'h00);
    W(2, 16'h0001, 8'h00, 16'h0000, 0);
    R(0, 8'h01, 16'h0000, 0);
    R(1, 8'h00, 16'h0001, 1);
    W(1, 16'h0001, 8'h00, 16'h0001, 1);
    R(1, 8'h00, 16'h0000, 0);
    W(3, 16'h0008, 8'h08, 16'h0000, 0);
    R(5, 8'h08, 16'h8003, 1);
    W(1, 16'h0008, 8'h08, 16'h0008, 1);
    R(1, 8'h08, 16'h0008, 1);
    R(1, 8'h00, 16'h0008, 1);
    R(1, 8'h00, 16'h0000, 0);
    W(6, 16'h0001, 8'h00, 16'h0000, 0);
    W(1, 16'h0001, 8'h01, 16'h0001, 1);
    R(1, 8'h00, 16'h0001, 1);
    W(1, 16'h0001, 8'h00, 16'h0001, 1);
    W(2, 16'h0024, 8'h24, 16'h0009, 0);
    R(5, 8'h24, 16'h8002, 1);
    W(4, 16'h0004, 8'h24, 16'h0000, 1);
    R(5, 8'h24, 16'h8005, 1);
    R(2, 8'h00, 16'h0020, 1);
    R(0, 8'h00, 16'h0000, 0);
    W(6, 16'h0003, 8'h00, 16'h0000, 0);
    W(3, 16'h0001, 8'h00, 16'h0000, 0);
    R(1, 8'h00, 16'h0001, 1);
    X(8'h00);
    R(1, 8'h00, 16'h0000, 0);
    R(2, 8'h00, 16'h0000, 0);
    W(2, 16'hFFFF, 8'h00, 16'h0000, 0);
    R(2, 8'h00, 16'h00FF, 0);
    W(4, 16'hFFFF, 8'h00, 16'h0000, 0);
    W(7, 16'hFFFF, 8'h00, 16'h0000, 0);
    R(7, 8'h00, 16'h0000, 0);
    R(2, 8'h00, 16'h0000, 0);
    X(8'h01);
    W(2, 16'h0001, 8'h01, 16'h0000, 0);
    R(1, 8'h01, 16'h0000, 0);
    R(1, 8'h00, 16'h0000, 0);

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].rst, vq[i].a, vq[i].cs, vq[i].wn,
            vq[i].wd, vq[i].in);
      cmp("vec", i, vq[i].rd, vq[i].irq);
    end

    rin = 0;
    for (int i = 0; i < 3000; i++) begin
      rin = rin ^ 8'($urandom & $urandom & $urandom);
      ra  = 3'($urandom_range(0, 7));
      rr  = ($urandom_range(0, 99) == 0);
      rc  = ($urandom_range(0, 3) != 0);
      rw  = ($urandom_range(0, 2) != 0);
      rwd = 16'($urandom);
      drive(rr, ra, rc, rw, rwd, rin);
      cmp("rand", i, m_rd, m_irq);
    end

    $display("Simulation finished: %0d checks, %0d errors",
      checks, errors);
    $finish;
  end

endmodule
